dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 32-bit RAM.
// Full-word writes go straight through. Partial writes use read-modify-write.
// Reads return data one cycle after the RAM access.
module dmem_arbiter #(
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_valid,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  input  logic [3:0]           m0_wstrb,
  output logic                 m0_ready,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_valid,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  input  logic [3:0]           m1_wstrb,
  output logic                 m1_ready,
  output logic [31:0]          m1_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic [1:0]           grant
);

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StReadWait,
    StRmwWait,
    StRmwWrite,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;  // 1: m1 was granted last
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [31:0]          merged_q, merged_d;
  logic [31:0]          m0_rdata_q, m0_rdata_d;
  logic [31:0]          m1_rdata_q, m1_rdata_d;
  logic                 sel_m1;

  // Byte-offset bits and bits above the RAM size are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_BITS+2], m0_addr[1:0],
                              m1_addr[31:ADDR_BITS+2], m1_addr[1:0]};

  // Round-robin pick: on a tie, grant the master that was not granted last.
  assign sel_m1 = m1_valid & (~m0_valid | ~last_q);

  // State and latched transaction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      merged_q   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      merged_q   <= merged_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Next-state logic, arbitration, read capture and byte merge.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    merged_d   = merged_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (m0_valid || m1_valid) begin
          grant_d = sel_m1 ? 2'b10 : 2'b01;
          addr_d  = sel_m1 ? m1_addr[ADDR_BITS+1:2] : m0_addr[ADDR_BITS+1:2];
          wdata_d = sel_m1 ? m1_wdata : m0_wdata;
          wstrb_d = sel_m1 ? m1_wstrb : m0_wstrb;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (wstrb_q == 4'hF) begin
          state_d = StDone;
        end else if (wstrb_q == 4'h0) begin
          state_d = StReadWait;
        end else begin
          state_d = StRmwWait;
        end
      end
      StReadWait: begin
        if (grant_q[1]) begin
          m1_rdata_d = ram_rdata;
        end else begin
          m0_rdata_d = ram_rdata;
        end
        state_d = StDone;
      end
      StRmwWait: begin
        for (int i = 0; i < 4; i++) begin
          merged_d[8*i+:8] = wstrb_q[i] ? wdata_q[8*i+:8] : ram_rdata[8*i+:8];
        end
        state_d = StRmwWrite;
      end
      StRmwWrite: begin
        state_d = StDone;
      end
      StDone: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // RAM and master outputs decoded from state and latched registers only.
  always_comb begin
    ram_en    = (state_q == StAccess) || (state_q == StRmwWrite);
    ram_we    = ((state_q == StAccess) && (wstrb_q == 4'hF)) || (state_q == StRmwWrite);
    ram_addr  = addr_q;
    ram_wdata = (state_q == StRmwWrite) ? merged_q : wdata_q;
    m0_ready  = (state_q == StDone) && grant_q[0];
    m1_ready  = (state_q == StDone) && grant_q[1];
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    grant     = grant_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a behavioural memory model.
module tb_dmem_arbiter;
  localparam int unsigned AB = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0]   m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          ram_en, ram_we;
  logic [AB-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [1:0]    grant;

  logic [31:0] ram [512];      // RAM attached to the DUT
  logic [31:0] exp_mem [512];  // reference contents
  logic [31:0] exp_rdata [2];
  int          model_last;
  int          n_cmp = 0;
  int          n_err = 0;

  dmem_arbiter #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  // Continuous protocol invariants.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if ((m0_ready && m1_ready) || (ram_we && !ram_en) ||
          (m0_ready && grant !== 2'b01) || (m1_ready && grant !== 2'b10)) begin
        n_err++;
        $display("FAIL invariant: rdy=%b%b we=%b en=%b grant=%b", m1_ready, m0_ready,
                 ram_we, ram_en, grant);
      end
    end
  end

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_ready : m1_ready;
  endfunction

  function automatic logic [31:0] rd(input int m);
    return (m == 0) ? m0_rdata : m1_rdata;
  endfunction

  task automatic drive(input int m, input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (m == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  task automatic set_valid(input int m, input logic v);
    if (m == 0) m0_valid = v;
    else        m1_valid = v;
  endtask

  // One transaction from an idle arbiter; checks RAM access, latency and rdata.
  task automatic run_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit drop_early);
    int lat, got, idx, o;
    logic [31:0] nw;
    logic [1:0] gexp;
    idx  = int'(a[AB+1:2]);
    o    = 1 - m;
    lat  = (s == 4'hF) ? 2 : ((s == 4'h0) ? 3 : 4);
    gexp = (m == 0) ? 2'b01 : 2'b10;
    if (s == 4'h0) begin
      exp_rdata[m] = exp_mem[idx];
    end else begin
      nw = exp_mem[idx];
      for (int b = 0; b < 4; b++) if (s[b]) nw[8*b+:8] = d[8*b+:8];
      exp_mem[idx] = nw;
    end
    drive(m, 1'b1, a, d, s);
    got = 0;
    for (int n = 1; n <= 12 && got == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        n_cmp++;
        if (ram_en !== 1'b1 || ram_we !== (s == 4'hF) || ram_addr !== idx[AB-1:0] ||
            grant !== gexp) begin
          n_err++;
          $display("FAIL access m%0d: en=%b we=%b addr=%0d grant=%b, want we=%b addr=%0d grant=%b",
                   m, ram_en, ram_we, ram_addr, grant, (s == 4'hF), idx, gexp);
        end
        if (drop_early) set_valid(m, 1'b0);
      end
      if (s != 4'h0 && n == lat - 1) begin
        n_cmp++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== exp_mem[idx]) begin
          n_err++;
          $display("FAIL write m%0d: en=%b we=%b wdata=%h, want wdata=%h", m, ram_en, ram_we,
                   ram_wdata, exp_mem[idx]);
        end
      end
      if (rdy(m)) got = n;
    end
    set_valid(m, 1'b0);
    n_cmp++;
    if (got != lat) begin
      n_err++;
      $display("FAIL latency m%0d strb=%h: got %0d, want %0d", m, s, got, lat);
    end
    n_cmp++;
    if (rd(m) !== exp_rdata[m]) begin
      n_err++;
      $display("FAIL rdata m%0d: got %h, want %h", m, rd(m), exp_rdata[m]);
    end
    n_cmp++;
    if (rd(o) !== exp_rdata[o]) begin
      n_err++;
      $display("FAIL other rdata m%0d: got %h, want %h", o, rd(o), exp_rdata[o]);
    end
    model_last = m;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || ram_en !== 1'b0 ||
        ram_we !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset outputs: grant=%b rdy=%b%b en=%b we=%b rd0=%h rd1=%h, want zeros",
               grant, m1_ready, m0_ready, ram_en, ram_we, m0_rdata, m1_rdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_txn(0, 32'h0000_0010, 32'hCAFE_BABE, 4'hF, 1'b0);
    run_txn(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    run_txn(0, 32'h0000_0010, 32'h1122_3344, 4'hF, 1'b0);
    run_txn(1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 1'b0);
    run_txn(1, 32'hFFFF_F810, 32'h0, 4'h0, 1'b0);  // aliases to word 4
  endtask

  task automatic test_random();
    int m, sel;
    logic [31:0] a, d;
    logic [3:0] s;
    for (int k = 0; k < 40; k++) begin
      m = int'($urandom_range(0, 1));
      a = $urandom;
      a[AB+1:2] = 9'($urandom_range(0, 7));
      d = $urandom;
      sel = int'($urandom_range(0, 2));
      s = (sel == 0) ? 4'h0 : ((sel == 1) ? 4'hF : 4'($urandom_range(1, 14)));
      run_txn(m, a, d, s, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_round_robin();
    int cnt, who, want;
    run_txn(0, 32'h20, 32'hA0A0_0000 | $urandom_range(0, 255), 4'hF, 1'b0);
    run_txn(1, 32'h24, 32'hB1B1_0000 | $urandom_range(0, 255), 4'hF, 1'b0);
    exp_rdata[0] = exp_mem[8];
    exp_rdata[1] = exp_mem[9];
    drive(0, 1'b1, 32'h20, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h24, 32'h0, 4'h0);
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 4; c++) begin
      @(posedge clk); #1;
      if (m0_ready || m1_ready) begin
        who  = m1_ready ? 1 : 0;
        want = 1 - model_last;
        n_cmp++;
        if (who != want || rd(who) !== exp_rdata[who]) begin
          n_err++;
          $display("FAIL rr order %0d: got m%0d rdata=%h, want m%0d rdata=%h", cnt, who,
                   rd(who), want, exp_rdata[want]);
        end
        model_last = who;
        cnt++;
        if (cnt == 4) begin
          set_valid(0, 1'b0);
          set_valid(1, 1'b0);
        end
      end
    end
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    n_cmp++;
    if (cnt != 4) begin
      n_err++;
      $display("FAIL rr count: got %0d, want 4", cnt);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_rmw();
    int got;
    run_txn(0, 32'h14, 32'h5566_7788, 4'hF, 1'b0);
    drive(1, 1'b1, 32'h14, 32'h0000_AB00, 4'b0010);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL rmw wait: en=%b we=%b, want 0 0", ram_en, ram_we);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || ram_en !== 1'b0 ||
        ram_we !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL async reset: grant=%b rdy=%b%b en=%b we=%b rd0=%h rd1=%h, want zeros",
               grant, m1_ready, m0_ready, ram_en, ram_we, m0_rdata, m1_rdata);
    end
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    model_last   = 1;
    set_valid(1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ram_we !== 1'b0) begin
        n_err++;
        $display("FAIL we in reset: got %b, want 0", ram_we);
      end
    end
    reset = 1'b0;
    exp_rdata[0] = exp_mem[5];
    drive(0, 1'b1, 32'h14, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h14, 32'h0, 4'h0);
    @(posedge clk); #1;
    n_cmp++;
    if (grant !== 2'b01) begin
      n_err++;
      $display("FAIL post-reset grant: got %b, want 01", grant);
    end
    set_valid(1, 1'b0);
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(posedge clk); #1;
      if (m0_ready) got = 1;
    end
    set_valid(0, 1'b0);
    n_cmp++;
    if (got != 1 || m0_rdata !== exp_rdata[0] || m1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL post-reset read: rdy=%0d rd0=%h rd1=%h, want 1 %h 0", got, m0_rdata,
               m1_rdata, exp_rdata[0]);
    end
    model_last = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (ram[5] !== exp_mem[5]) begin
      n_err++;
      $display("FAIL ram word 5: got %h, want %h", ram[5], exp_mem[5]);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]     = 32'h0;
      exp_mem[i] = 32'h0;
    end
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    model_last   = 1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_directed();
    test_random();
    test_round_robin();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
